// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU timing blocks: sequencer states,
// interrupt vector selector codes and entry-sequence cycle indices.
package tiny_cpu_pkg;

    typedef enum logic [1:0] {
        ST_RST_SEQ = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXEC    = 2'd2,
        ST_INT_SEQ = 2'd3
    } seq_state_e;

    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_NMI  = 2'b01;
    localparam logic [1:0] VEC_RST  = 2'b10;
    localparam logic [1:0] VEC_IRQ  = 2'b11;

    localparam int SEQ_LEN_DEFAULT  = 7;
    localparam int VEC_FETCH_LO_IDX = 5;
    localparam int VEC_FETCH_HI_IDX = 6;

    // Decoder values below two cannot describe a real instruction; run them as two.
    function automatic logic [2:0] effective_cycles(input logic [2:0] raw);
        return (raw < 3'd2) ? 3'd2 : raw;
    endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the active-low NMI line with a sticky pending flag.
module nmi_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic NMI,
    input  logic clear,
    output logic pending
);

    logic nmi_prev_q;
    logic pending_q;
    logic pending_d;
    logic fall;

    // The edge seen this cycle is visible immediately so it can be serviced
    // by an instruction that ends in the very cycle NMI drops.
    assign fall      = nmi_prev_q & ~NMI;
    assign pending   = pending_q | fall;
    assign pending_d = pending & ~clear;

    always_ff @(posedge CLK) begin
        if (RST) begin
            nmi_prev_q <= 1'b1;
            pending_q  <= 1'b0;
        end else begin
            nmi_prev_q <= NMI;
            pending_q  <= pending_d;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: reset/interrupt entry sequences, opcode fetch
// and execute timing, RDY stalling and NMI/IRQ arbitration.
module cycle_sequencer
    import tiny_cpu_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter int TW      = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RDY,
    input  logic          IRQ,
    input  logic          NMI,
    input  logic          I_FLAG,
    input  logic [2:0]    INSN_CYCLES,
    output logic [TW-1:0] TSTATE,
    output logic          SYNC,
    output logic          IRI,
    output logic          PC_INC,
    output logic          INT_ACTIVE,
    output logic [1:0]    VECTOR_SEL,
    output logic          VEC_FETCH
);

    seq_state_e    state_q, state_d;
    logic [TW-1:0] tstate_q, tstate_d;
    logic [2:0]    held_q, held_d;
    logic [1:0]    vec_q, vec_d;

    logic          nmi_pending;
    logic          nmi_clear;
    logic [2:0]    eff_cycles;
    logic          first_exec;
    logic          exec_last;
    logic          seq_last;
    logic          in_entry;
    logic          vec_window;

    nmi_edge_detect u_nmi (
        .CLK     (CLK),
        .RST     (RST),
        .NMI     (NMI),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    // At TSTATE 1 the decoder value is used directly so a two-cycle
    // instruction can finish in the same cycle it is sampled.
    assign first_exec = (state_q == ST_EXEC) && (tstate_q == TW'(1));
    assign eff_cycles = first_exec ? effective_cycles(INSN_CYCLES) : held_q;
    assign exec_last  = (tstate_q == TW'(eff_cycles - 3'd1));
    assign seq_last   = (tstate_q == TW'(SEQ_LEN - 1));

    always_comb begin
        state_d   = state_q;
        tstate_d  = tstate_q;
        held_d    = held_q;
        vec_d     = vec_q;
        nmi_clear = 1'b0;
        if (RDY) begin
            unique case (state_q)
                ST_RST_SEQ, ST_INT_SEQ: begin
                    if (seq_last) begin
                        state_d  = ST_FETCH;
                        tstate_d = '0;
                    end else begin
                        tstate_d = tstate_q + TW'(1);
                    end
                end
                ST_FETCH: begin
                    state_d  = ST_EXEC;
                    tstate_d = TW'(1);
                end
                ST_EXEC: begin
                    if (first_exec) begin
                        held_d = eff_cycles;
                    end
                    if (exec_last) begin
                        tstate_d = '0;
                        if (nmi_pending) begin
                            state_d   = ST_INT_SEQ;
                            vec_d     = VEC_NMI;
                            nmi_clear = 1'b1;
                        end else if (!IRQ && !I_FLAG) begin
                            state_d = ST_INT_SEQ;
                            vec_d   = VEC_IRQ;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        tstate_d = tstate_q + TW'(1);
                    end
                end
                default: begin
                    state_d  = ST_RST_SEQ;
                    tstate_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RST_SEQ;
            tstate_q <= '0;
            held_q   <= 3'd2;
            vec_q    <= VEC_NONE;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
            held_q   <= held_d;
            vec_q    <= vec_d;
        end
    end

    assign in_entry   = (state_q == ST_RST_SEQ) || (state_q == ST_INT_SEQ);
    assign vec_window = (tstate_q == TW'(VEC_FETCH_LO_IDX)) ||
                        (tstate_q == TW'(VEC_FETCH_HI_IDX));

    // RST masks every strobe; RDY only masks the strobes that cause side effects.
    always_comb begin
        TSTATE     = tstate_q;
        SYNC       = !RST && (state_q == ST_FETCH);
        IRI        = SYNC && RDY;
        PC_INC     = SYNC && RDY;
        INT_ACTIVE = !RST && in_entry;
        VEC_FETCH  = INT_ACTIVE && vec_window && RDY;
        if (RST) begin
            VECTOR_SEL = VEC_NONE;
        end else if (state_q == ST_RST_SEQ) begin
            VECTOR_SEL = VEC_RST;
        end else if (state_q == ST_INT_SEQ) begin
            VECTOR_SEL = vec_q;
        end else begin
            VECTOR_SEL = VEC_NONE;
        end
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter: SEQ_LEN, default 7, cycles in a reset or interrupt entry sequence.
REQ-002 Parameter: TW, default 3, width of TSTATE.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 RDY  in  1  high = advance; low = stall the sequencer.
REQ-006 IRQ  in  1  maskable interrupt request, active-low, level.
REQ-007 NMI  in  1  non-maskable interrupt, active-low, falling-edge triggered.
REQ-008 I_FLAG  in  1  interrupt-disable flag from the status register.
REQ-009 INSN_CYCLES  in  3  total cycles of the current instruction, from the decoder, valid from cycle index 1.
REQ-010 TSTATE  out  TW  cycle index within the current instruction or sequence; 0 = first cycle.
REQ-011 SYNC  out  1  high during the opcode-fetch cycle.
REQ-012 IRI  out  1  instruction-register load strobe.
REQ-013 PC_INC  out  1  program-counter increment strobe.
REQ-014 INT_ACTIVE  out  1  high throughout a reset or interrupt entry sequence.
REQ-015 VECTOR_SEL  out  2  00 none, 01 NMI (FFFA), 10 RESET (FFFC), 11 IRQ (FFFE).
REQ-016 VEC_FETCH  out  1  high in the last two cycles of an entry sequence (low byte, then high byte).

Function
REQ-017 The states SHALL be RST_SEQ, FETCH, EXEC and INT_SEQ, held with a TW-bit cycle counter.
REQ-018 RST_SEQ SHALL run SEQ_LEN cycles (TSTATE 0..6) with INT_ACTIVE=1 and VECTOR_SEL=10, then go to FETCH.
REQ-019 FETCH SHALL be one cycle with TSTATE=0, SYNC=1, IRI=1 and PC_INC=1, then go to EXEC with TSTATE=1.
REQ-020 EXEC SHALL sample INSN_CYCLES at TSTATE=1 into a held register; values 0 and 1 SHALL be treated as 2.
REQ-021 EXEC SHALL increment TSTATE each cycle; the last cycle is TSTATE = held_cycles-1.
REQ-022 The last EXEC cycle SHALL transition to INT_SEQ(NMI) if NMI is pending.
REQ-023 Otherwise, it SHALL transition to INT_SEQ(IRQ) if IRQ=0 and I_FLAG=0 in that cycle.
REQ-024 Otherwise, it SHALL transition to FETCH.
REQ-025 INT_SEQ SHALL run SEQ_LEN cycles with INT_ACTIVE=1 and VECTOR_SEL=01 (NMI) or 11 (IRQ) latched at entry, then go to FETCH.
REQ-026 VEC_FETCH SHALL be 1 at TSTATE 5 and 6 of RST_SEQ and INT_SEQ, and 0 otherwise.
REQ-027 VECTOR_SEL SHALL be 00 in FETCH and EXEC.
REQ-028 NMI SHALL be sampled every cycle, including while RDY=0; a 1->0 transition between consecutive samples SHALL set nmi_pending.
REQ-029 nmi_pending SHALL clear on the cycle INT_SEQ(NMI) is entered.
REQ-030 A new NMI edge during INT_SEQ SHALL set nmi_pending again and be serviced after the next instruction.
REQ-031 NMI held low SHALL NOT re-trigger.
REQ-032 NMI SHALL take priority when NMI and IRQ are both pending.
REQ-033 IRQ SHALL NOT be latched; deasserting it before the last EXEC cycle loses the request.
REQ-034 RDY=0 SHALL freeze state, TSTATE, the held cycle count and VECTOR_SEL.
REQ-035 RDY=0 SHALL force IRI=0, PC_INC=0 and VEC_FETCH=0.
REQ-036 SYNC and INT_ACTIVE SHALL hold their values while RDY=0.
REQ-037 All outputs SHALL decode combinationally from registered state, except the RDY gating in REQ-035.

Reset
REQ-038 At a rising CLK edge with RST=1, the block SHALL load state=RST_SEQ, TSTATE=0, nmi_pending=0, the previous NMI sample=1 and held_cycles=2.
REQ-039 While RST=1, the block SHALL output SYNC=0, IRI=0, PC_INC=0, INT_ACTIVE=0, VECTOR_SEL=00 and VEC_FETCH=0.
REQ-040 RST SHALL override RDY.
REQ-041 Assertion of RST at any point, including mid-instruction or mid-INT_SEQ, SHALL abort and restart RST_SEQ after release.
REQ-042 The first cycle after RST falls SHALL be RST_SEQ TSTATE 0.

Structure
REQ-043 The shared package tiny_cpu_pkg SHALL hold: the state enum; VECTOR_SEL constants (VEC_NONE, VEC_NMI, VEC_RST, VEC_IRQ); default SEQ_LEN; VEC_FETCH cycle indices 5 and 6.
REQ-044 The block SHALL contain one sub-module, nmi_edge_detect, with ports CLK, RST, NMI, clear and pending.

Verification
REQ-045 Reset release, RDY=1, INSN_CYCLES=2 -> RST_SEQ TSTATE 0..6, VECTOR_SEL=10, VEC_FETCH at 5,6; then FETCH with SYNC=IRI=PC_INC=1, then EXEC TSTATE 1, then FETCH.
REQ-046 INSN_CYCLES=4 with RDY=0 for 3 cycles at TSTATE 2 -> TSTATE held at 2 for 3 cycles with PC_INC=0, then 3, then FETCH; total 7 cycles from the FETCH.
REQ-047 IRQ=0, I_FLAG=0 at the last EXEC cycle -> INT_SEQ, VECTOR_SEL=11 for 7 cycles; repeated with I_FLAG=1 -> FETCH and no INT_SEQ.
REQ-048 NMI pulse low 1 cycle at EXEC TSTATE 1 with IRQ=0, I_FLAG=0 -> INT_SEQ with VECTOR_SEL=01; then IRQ serviced after the next instruction.
REQ-049 NMI held low 20 cycles -> exactly one INT_SEQ(NMI); NMI falling during RDY=0 -> serviced after the stall ends.
REQ-050 RST=1 for 1 cycle during INT_SEQ TSTATE 4 -> outputs are reset values, then a full RST_SEQ; nmi_pending=0.
